axi_rtc_up_axi: RTL and testbench

- AXI4-Lite slave that acts as the initiator on the up_* register bus: it converts AXI reads and writes into single-cycle up_wreq/up_rreq pulses and waits for the matching up_wack/up_rack.
- Sits between the processor interconnect and axi_rtc_regs.
- Serializes traffic: one transaction in flight. Arbitrates between reads and writes and times out unresponsive accesses with SLVERR.

---
 rtl/axi_rtc_up_axi.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_rtc_up_axi.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rtc_up_axi.sv
// AXI4-Lite slave that initiates single-cycle up_wreq/up_rreq accesses on the
// up_* register bus, one transaction at a time, with ack timeout and SLVERR.
module axi_rtc_up_axi #(
   parameter int ADDR_WIDTH = 14,
   parameter int TIMEOUT    = 255
) (
   input  logic                  up_clk,
   input  logic                  up_rstn,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [ADDR_WIDTH+1:0] s_axi_awaddr,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   output logic [1:0]            s_axi_bresp,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [ADDR_WIDTH+1:0] s_axi_araddr,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  up_wreq,
   output logic [ADDR_WIDTH-1:0] up_waddr,
   output logic [31:0]           up_wdata,
   input  logic                  up_wack,
   output logic                  up_rreq,
   output logic [ADDR_WIDTH-1:0] up_raddr,
   input  logic [31:0]           up_rdata,
   input  logic                  up_rack
);

   typedef enum logic [2:0] {IDLE, WREQ, WWAIT, BRESP, RREQ, RWAIT, RRESP} state_t;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t                state_q, state_d;
   logic                  prio_wr_q, prio_wr_d;
   logic                  strb_ok_q, strb_ok_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  awready_q, awready_d;
   logic                  arready_q, arready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  up_wreq_q, up_wreq_d;
   logic [ADDR_WIDTH-1:0] up_waddr_q, up_waddr_d;
   logic [31:0]           up_wdata_q, up_wdata_d;
   logic                  up_rreq_q, up_rreq_d;
   logic [ADDR_WIDTH-1:0] up_raddr_q, up_raddr_d;

   logic wr_cand, rd_cand, expired;

   // Byte-lane bits of the AXI address carry no information on a word bus.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   assign wr_cand = s_axi_awvalid && s_axi_wvalid;
   assign rd_cand = s_axi_arvalid;
   assign expired = (cnt_q == TIMEOUT_CNT);

   always_comb begin
      // NOTE: every _d gets a default before the case so no path can infer a latch.
      state_d    = state_q;
      prio_wr_d  = prio_wr_q;
      strb_ok_d  = strb_ok_q;
      cnt_d      = cnt_q;
      awready_d  = 1'b0;
      arready_d  = 1'b0;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      up_wreq_d  = 1'b0;
      up_waddr_d = up_waddr_q;
      up_wdata_d = up_wdata_q;
      up_rreq_d  = 1'b0;
      up_raddr_d = up_raddr_q;

      case (state_q)
         IDLE: begin
            // Contention flips priority; an uncontested request leaves it alone.
            if (wr_cand && (!rd_cand || prio_wr_q)) begin
               state_d   = WREQ;
               awready_d = 1'b1;
               strb_ok_d = (s_axi_wstrb == 4'hF);
               if (s_axi_wstrb == 4'hF) begin
                  up_waddr_d = s_axi_awaddr[ADDR_WIDTH+1:2];
                  up_wdata_d = s_axi_wdata;
               end
               if (rd_cand) prio_wr_d = 1'b0;
            end else if (rd_cand) begin
               state_d    = RREQ;
               arready_d  = 1'b1;
               up_raddr_d = s_axi_araddr[ADDR_WIDTH+1:2];
               if (wr_cand) prio_wr_d = 1'b1;
            end
         end
         WREQ: begin
            if (strb_ok_q) begin
               up_wreq_d = 1'b1;
               cnt_d     = '0;
               state_d   = WWAIT;
            end else begin
               bvalid_d = 1'b1;
               bresp_d  = RESP_SLVERR;
               state_d  = BRESP;
            end
         end
         WWAIT: begin
            if (up_wack) begin
               bvalid_d = 1'b1;
               bresp_d  = RESP_OKAY;
               state_d  = BRESP;
            end else if (expired) begin
               bvalid_d = 1'b1;
               bresp_d  = RESP_SLVERR;
               state_d  = BRESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         BRESP: begin
            if (s_axi_bready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         RREQ: begin
            up_rreq_d = 1'b1;
            cnt_d     = '0;
            state_d   = RWAIT;
         end
         RWAIT: begin
            if (up_rack) begin
               rvalid_d = 1'b1;
               rresp_d  = RESP_OKAY;
               rdata_d  = up_rdata;
               state_d  = RRESP;
            end else if (expired) begin
               rvalid_d = 1'b1;
               rresp_d  = RESP_SLVERR;
               rdata_d  = '0;
               state_d  = RRESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RRESP: begin
            if (s_axi_rready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         state_q    <= IDLE;
         prio_wr_q  <= 1'b1;
         strb_ok_q  <= 1'b0;
         cnt_q      <= '0;
         awready_q  <= 1'b0;
         arready_q  <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
         rvalid_q   <= 1'b0;
         rresp_q    <= '0;
         rdata_q    <= '0;
         up_wreq_q  <= 1'b0;
         up_waddr_q <= '0;
         up_wdata_q <= '0;
         up_rreq_q  <= 1'b0;
         up_raddr_q <= '0;
      end else begin
         state_q    <= state_d;
         prio_wr_q  <= prio_wr_d;
         strb_ok_q  <= strb_ok_d;
         cnt_q      <= cnt_d;
         awready_q  <= awready_d;
         arready_q  <= arready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         up_wreq_q  <= up_wreq_d;
         up_waddr_q <= up_waddr_d;
         up_wdata_q <= up_wdata_d;
         up_rreq_q  <= up_rreq_d;
         up_raddr_q <= up_raddr_d;
      end
   end

   // AW and W are always accepted together.
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = awready_q;
   assign s_axi_arready = arready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign up_wreq       = up_wreq_q;
   assign up_waddr      = up_waddr_q;
   assign up_wdata      = up_wdata_q;
   assign up_rreq       = up_rreq_q;
   assign up_raddr      = up_raddr_q;

endmodule

// File: tb/tb_axi_rtc_up_axi.sv
// Bench for axi_rtc_up_axi: vector table of single accesses against a small
// 1-cycle-ack register file model, plus arbitration, timeout, hold and reset sequences.
module tb_axi_rtc_up_axi;

   localparam int AW = 14;

   logic          up_clk = 1'b0;
   logic          up_rstn = 1'b0;
   logic          s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
   logic          s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
   logic [AW+1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
   logic [31:0]   s_axi_wdata = '0;
   logic [3:0]    s_axi_wstrb = '0;
   logic          s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
   logic [1:0]    s_axi_bresp, s_axi_rresp;
   logic [31:0]   s_axi_rdata;
   logic          up_wreq, up_rreq;
   logic [AW-1:0] up_waddr, up_raddr;
   logic [31:0]   up_wdata;
   logic          up_wack = 1'b0, up_rack = 1'b0;
   logic [31:0]   up_rdata = '0;

   axi_rtc_up_axi #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
      .up_clk(up_clk), .up_rstn(up_rstn),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
      .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
   );

   always #5 up_clk = ~up_clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge up_clk) cyc <= cyc + 1;

   // Register file model: acks one cycle after each request.
   logic [31:0] mem [16];
   logic wack_en = 1'b1, rack_en = 1'b1, rack_inject = 1'b0;
   initial for (int i = 0; i < 16; i++) mem[i] = '0;
   always @(posedge up_clk) begin
      up_wack <= up_wreq & wack_en;
      if (up_wreq) mem[up_waddr[3:0]] <= up_wdata;
      up_rack  <= (up_rreq & rack_en) | rack_inject;
      up_rdata <= up_rreq ? mem[up_raddr[3:0]] : 32'hBAD0_BAD0;
   end

   int wreq_cnt = 0, both_cnt = 0;
   always @(negedge up_clk) begin
      if (up_wreq) wreq_cnt++;
      if (up_wreq && up_rreq) both_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge up_clk);
      #1;
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int hold, output logic [1:0] resp, output int lat);
      int hs, bc;
      logic stable;
      hs = -1; bc = -1; resp = 2'b11; lat = -1;
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = (hold == 0);
      for (int i = 0; i < 50; i++) begin
         if (s_axi_awready) begin hs = cyc; break; end
         step();
      end
      if (hs < 0) begin
         check("aw_accept_timeout", 0, 1);
         s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
         return;
      end
      check("wready_with_awready", s_axi_wready, 1);
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (s_axi_bvalid) begin bc = cyc; break; end
         step();
      end
      if (bc < 0) begin
         check("bvalid_timeout", 0, 1);
         return;
      end
      lat = bc - hs;
      resp = s_axi_bresp;
      if (hold > 0) begin
         s_axi_araddr = a; s_axi_arvalid = 1'b1;
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            step();
            if (!s_axi_bvalid || s_axi_bresp !== resp || s_axi_awready || s_axi_arready) stable = 1'b0;
         end
         check("b_hold_stable", stable, 1);
         s_axi_bready = 1'b1;
      end
      step();
      check("bvalid_cleared", s_axi_bvalid, 0);
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [15:0] a, input int hold, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
      int hs, rc;
      logic stable;
      hs = -1; rc = -1; data = 'x; resp = 2'b11; lat = -1;
      s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = (hold == 0);
      for (int i = 0; i < 50; i++) begin
         if (s_axi_arready) begin hs = cyc; break; end
         step();
      end
      if (hs < 0) begin
         check("ar_accept_timeout", 0, 1);
         s_axi_arvalid = 1'b0;
         return;
      end
      step();
      s_axi_arvalid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (s_axi_rvalid) begin rc = cyc; break; end
         step();
      end
      if (rc < 0) begin
         check("rvalid_timeout", 0, 1);
         return;
      end
      lat = rc - hs;
      data = s_axi_rdata;
      resp = s_axi_rresp;
      if (hold > 0) begin
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            step();
            if (!s_axi_rvalid || s_axi_rdata !== data || s_axi_rresp !== resp ||
                s_axi_awready || s_axi_arready) stable = 1'b0;
         end
         check("r_hold_stable", stable, 1);
         s_axi_rready = 1'b1;
      end
      step();
      check("rvalid_cleared", s_axi_rvalid, 0);
      s_axi_rready = 1'b0;
   endtask

   // Both sides presented at once; records which ready fires first and the read data.
   task automatic arb_round(input logic [15:0] wa, input logic [31:0] wd, input logic [15:0] ra,
                            output int aw_c, output int ar_c, output logic [31:0] rd);
      logic drop_aw, drop_ar;
      aw_c = -1; ar_c = -1; rd = 'x; drop_aw = 1'b0; drop_ar = 1'b0;
      s_axi_awaddr = wa; s_axi_wdata = wd; s_axi_wstrb = 4'hF; s_axi_araddr = ra;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (drop_aw) begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; drop_aw = 1'b0; end
         if (drop_ar) begin s_axi_arvalid = 1'b0; drop_ar = 1'b0; end
         if (s_axi_awready && aw_c < 0) begin aw_c = cyc; drop_aw = 1'b1; end
         if (s_axi_arready && ar_c < 0) begin ar_c = cyc; drop_ar = 1'b1; end
         if (s_axi_rvalid) rd = s_axi_rdata;
      end
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      int          lat;
      int          nreq;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #200000;
      $display("FAIL global_time_limit: got run still active, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;
      int          lat, w0, aw_c, ar_c;

      vecs[0] = '{1'b1, 16'h0008, 32'hA5A5_0001, 4'hF, 2'b00, 3, 1};
      vecs[1] = '{1'b0, 16'h0008, 32'hA5A5_0001, 4'hF, 2'b00, 3, 0};
      vecs[2] = '{1'b1, 16'h000C, 32'h1234_5678, 4'hF, 2'b00, 3, 1};
      vecs[3] = '{1'b1, 16'h0013, 32'hDEAD_BEEF, 4'hF, 2'b00, 3, 1};
      vecs[4] = '{1'b0, 16'h000E, 32'h1234_5678, 4'hF, 2'b00, 3, 0};
      vecs[5] = '{1'b0, 16'h0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 3, 0};
      vecs[6] = '{1'b1, 16'h0008, 32'hFFFF_FFFF, 4'h3, 2'b10, 1, 0};
      vecs[7] = '{1'b0, 16'h0008, 32'hA5A5_0001, 4'hF, 2'b00, 3, 0};

      step(); step();
      check("rst_awready", s_axi_awready, 0);
      check("rst_arready", s_axi_arready, 0);
      check("rst_valids", {s_axi_bvalid, s_axi_rvalid, up_wreq, up_rreq}, 0);
      check("rst_addrs", {up_waddr, up_raddr}, 0);
      check("rst_rdata", s_axi_rdata, 0);
      up_rstn = 1'b1;
      step();

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            w0 = wreq_cnt;
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp, lat);
            check($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
            check($sformatf("v%0d_blat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_wreq_pulses", i), wreq_cnt - w0, vecs[i].nreq);
            if (vecs[i].nreq == 1) begin
               check($sformatf("v%0d_waddr", i), up_waddr, 32'(vecs[i].addr[15:2]));
               check($sformatf("v%0d_wdata", i), up_wdata, vecs[i].data);
            end
         end else begin
            axi_read(vecs[i].addr, 0, rd, resp, lat);
            check($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
            check($sformatf("v%0d_rlat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].data);
            check($sformatf("v%0d_raddr", i), up_raddr, 32'(vecs[i].addr[15:2]));
         end
         step();
      end

      // Arbitration: write holds priority after reset, then read does.
      arb_round(16'h0014, 32'h0BAD_CAFE, 16'h0008, aw_c, ar_c, rd);
      check("arb1_both_served", (aw_c >= 0) && (ar_c >= 0), 1);
      check("arb1_write_first", aw_c < ar_c, 1);
      check("arb1_spacing", (ar_c - aw_c) >= 4, 1);
      check("arb1_rdata", rd, 32'hA5A5_0001);
      step();
      arb_round(16'h0018, 32'h55AA_55AA, 16'h0014, aw_c, ar_c, rd);
      check("arb2_both_served", (aw_c >= 0) && (ar_c >= 0), 1);
      check("arb2_read_first", ar_c < aw_c, 1);
      check("arb2_spacing", (aw_c - ar_c) >= 4, 1);
      check("arb2_rdata", rd, 32'h0BAD_CAFE);
      step();
      axi_read(16'h0018, 0, rd, resp, lat);
      check("arb2_write_landed", rd, 32'h55AA_55AA);

      // Read timeout, then a stray late ack must not satisfy the next read.
      rack_en = 1'b0;
      axi_read(16'h000C, 0, rd, resp, lat);
      check("to_rresp", resp, 2'b10);
      check("to_rdata", rd, 0);
      check("to_latency", lat, 18);
      rack_inject = 1'b1;
      step();
      rack_inject = 1'b0;
      rack_en = 1'b1;
      step(); step();
      axi_read(16'h000C, 0, rd, resp, lat);
      check("post_to_rresp", resp, 2'b00);
      check("post_to_rdata", rd, 32'h1234_5678);
      check("post_to_latency", lat, 3);

      // Backpressure: hold bready low with a read pending, then rready low.
      axi_write(16'h001C, 32'hCAFE_0007, 4'hF, 10, resp, lat);
      check("bp_bresp", resp, 2'b00);
      axi_read(16'h001C, 10, rd, resp, lat);
      check("bp_rdata", rd, 32'hCAFE_0007);
      check("bp_rresp", resp, 2'b00);
      step();

      // Reset while the write waits for an ack that never comes.
      wack_en = 1'b0;
      s_axi_awaddr = 16'h0020; s_axi_wdata = 32'h7777_0000; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      for (int i = 0; i < 10 && !s_axi_awready; i++) step();
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("mid_wreq_high", up_wreq, 1);
      #2 up_rstn = 1'b0;
      #1;
      check("mid_rst_wreq", up_wreq, 0);
      check("mid_rst_outs", {s_axi_awready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 0);
      check("mid_rst_waddr", up_waddr, 0);
      step(); step();
      check("mid_rst_no_bvalid", s_axi_bvalid, 0);
      up_rstn = 1'b1;
      wack_en = 1'b1;
      step();
      axi_write(16'h0024, 32'h0F0F_1234, 4'hF, 0, resp, lat);
      check("after_rst_bresp", resp, 2'b00);
      check("after_rst_blat", lat, 3);
      axi_read(16'h0024, 0, rd, resp, lat);
      check("after_rst_rdata", rd, 32'h0F0F_1234);

      check("wreq_rreq_never_together", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
